// File: rtl/regfile_write_sched_pkg.sv
// Shared register-file definitions for the write-port scheduler.
// Geometry constants, FSM state type and an index-width helper.
package regfile_write_sched_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_sched_rr_arbiter.sv
// N-way round-robin arbiter: purely combinational.
// Searches from ptr upward (mod N) for the first request.
module rr_arbiter
  import regfile_write_sched_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  int idx;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(i_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_grant[idx] = 1'b1;
        o_winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Owns the register-file write port: zero sweep after reset/clear,
// then round-robin arbitration of writeback requesters.
module regfile_write_sched
  import regfile_write_sched_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int DATA_W       = REG_DATA_W,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [N_REQ*DATA_W-1:0] i_req_val,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_RegWrite,
  output logic [ADDR_W-1:0]       o_regW_addr,
  output logic [DATA_W-1:0]       o_regW_val,
  output logic                    o_init_done
);

  localparam int IW = idx_w(N_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   val_q, val_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [IW-1:0]       arb_winner;
  logic                arb_any;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_val;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .i_req    (i_req_valid),
    .i_ptr    (ptr_q),
    .o_grant  (arb_grant),
    .o_winner (arb_winner),
    .o_any    (arb_any)
  );

  assign win_addr = i_req_addr[int'(arb_winner)*ADDR_W +: ADDR_W];
  assign win_val  = i_req_val[int'(arb_winner)*DATA_W +: DATA_W];

  // Next-state: sweep in INIT, arbitration in RUN, clear wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    val_d       = val_q;
    o_req_ready = '0;
    unique case (state_q)
      ST_INIT: begin
        if (i_clear) begin
          cnt_d = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          val_d  = '0;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (i_clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (arb_any) begin
          o_req_ready = arb_grant;
          addr_d      = win_addr;
          val_d       = win_val;
          we_d        = !(R0_HARDWIRED && (win_addr == '0));
          if (arb_winner == IW'(N_REQ - 1))
            ptr_d = '0;
          else
            ptr_d = arb_winner + 1'b1;
        end
      end
    endcase
  end

  // State, pointer, counter and write-port registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
    end
  end

  assign o_RegWrite  = we_q;
  assign o_regW_addr = addr_q;
  assign o_regW_val  = val_q;
  assign o_init_done = (state_q == ST_RUN);

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Write-port scheduler for the 32x32 CPU register file; owns the file's single write port (write enable, address, data).
- Runs a reset/clear sweep that writes zero to all 32 registers.
- Then round-robin arbitrates N writeback requesters (e.g. ALU, load unit, debug) onto that port using valid/ready handshakes.
- Sits between the writeback sources and the register file.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width
- R0_HARDWIRED, 1, when 1 a granted write to address 0 is consumed but the write enable stays low

Ports:
- i_clock  in  1  clock, rising edge
- i_reset  in  1  asynchronous active-high reset
- i_clear  in  1  pulse: restart the zero sweep
- i_req_valid  in  N_REQ  per-requester write request
- i_req_addr  in  N_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- i_req_val  in  N_REQ*DATA_W  packed data, requester k at [k*DATA_W +: DATA_W]
- o_req_ready  out  N_REQ  one-hot grant (combinational)
- o_RegWrite  out  1  register-file write enable (registered)
- o_regW_addr  out  ADDR_W  write address (registered)
- o_regW_val  out  DATA_W  write data (registered)
- o_init_done  out  1  high in RUN state

Behaviour:
- Reset (async, i_reset=1): state=INIT, sweep counter=0, rr pointer=0, o_RegWrite=0, o_regW_addr=0, o_regW_val=0, o_req_ready=0, o_init_done=0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle, register o_RegWrite=1, o_regW_addr=counter, o_regW_val=0; then counter++.
  - After the cycle issuing address 31, go to RUN; counter returns to 0.
  - Sweep takes exactly 32 cycles; the last sweep write is visible the same edge state becomes RUN.
  - o_req_ready=0 throughout INIT.
  - i_clear during INIT: counter=0, sweep restarts.
- RUN:
  - Winner = first k with i_req_valid[k]=1, searching k = ptr, ptr+1, ... mod N_REQ.
  - o_req_ready[winner]=1; all other ready bits 0; all 0 if no valid.
  - Transfer when valid&ready. Next edge registers o_regW_addr/o_regW_val from the winner and sets o_RegWrite=1. Latency is 1 cycle from accept to write-port drive.
  - On a transfer, ptr=(winner+1) mod N_REQ; with no transfer ptr holds.
  - No transfer: o_RegWrite=0 next cycle; addr/val hold their previous values.
  - R0_HARDWIRED=1 and winner address=0: transfer completes (ready=1, ptr advances) but o_RegWrite=0 next cycle.
  - i_clear=1 in RUN takes priority over arbitration: o_req_ready=0 that cycle; next state INIT with counter=0.
- Requester rules:
  - Hold valid/addr/val stable until ready.
  - Ready may assert in the same cycle as valid; no combinational path from ready to valid.
- Throughput: one write per cycle sustained in RUN. Starvation-free: any held request is granted within N_REQ cycles.
- Reset mid-sweep or mid-transfer: the pending registered write is dropped (o_RegWrite forced to 0 immediately); sweep restarts from 0.
- ptr wrap: modulo N_REQ; N_REQ need not be a power of 2.

Decomposition:
- Shared cpu package:
  - REG_COUNT=32, REG_ADDR_W=5, REG_DATA_W=32
  - state enum {ST_INIT, ST_RUN}
- One sub-module: rr_arbiter (N-way round-robin, inputs req and ptr, outputs one-hot grant and winner index); purely combinational and reusable.
- Pointer, FSM, counter and output registers live in regfile_write_sched.

Test Plan:
- Reset then idle for 34 cycles: o_RegWrite=1 for exactly 32 consecutive cycles with addresses 0..31, data 0; then o_init_done=1, o_RegWrite=0; o_req_ready stays 0 during the sweep.
- RUN, all 3 valid and held, addresses 5/6/7, data 0xA/0xB/0xC: grants in order 0,1,2,0,... (one per cycle); o_regW_addr one cycle later is 5,6,7,5.
- RUN, only requester 2 valid (addr 3, val 0xDEADBEEF): ready[2]=1 the same cycle; next cycle o_RegWrite=1, addr 3, val 0xDEADBEEF; ptr becomes 0.
- RUN, requester 1 writes addr 0, val 0x1234 with R0_HARDWIRED=1: ready[1]=1, next cycle o_RegWrite=0; the next grant starts search at requester 2.
- i_clear pulse while requester 0 is valid: no ready that cycle; 32-cycle zero sweep follows; requester 0 is granted on the first RUN cycle.
- Assert i_reset asynchronously mid-sweep (counter=17): o_RegWrite=0 immediately without a clock edge; after release the sweep restarts at address 0.
